fx2_stream_feeder: RTL



---
 rtl/fx2_stream_feeder_pkg.sv | 21 ++
 rtl/fx2_stream_feeder_sample_fifo.sv | 60 ++++++
 rtl/fx2_stream_feeder.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fx2_stream_feeder_pkg.sv
// rtl/fx2_stream_feeder_pkg.sv - shared states, FX2 flag polarities and serve timing for the stream feeder
package fx2_stream_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } feeder_state_e;

    // FX2 slave FIFO flags and strobes are all active-low.
    localparam logic FX2_EMPTY_N_ACTIVE = 1'b0;
    localparam logic FX2_STROBE_ON      = 1'b0;
    localparam logic FX2_STROBE_OFF     = 1'b1;

    localparam int SERVE_SETUP_CYCLES = 1;
    localparam int SERVE_OK_CYCLES    = 2;
    localparam int SERVE_LAST         = SERVE_SETUP_CYCLES + SERVE_OK_CYCLES;
    localparam int SERVE_CNT_W        = $clog2(SERVE_LAST + 1);

endpackage

// File: rtl/fx2_stream_feeder_sample_fifo.sv
// rtl/fx2_stream_feeder_sample_fifo.sv - synchronous DEPTH x DATA_W sample buffer with flush
module fx2_stream_feeder_sample_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     wr_en_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     rd_en_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en_i) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_en_i && !empty_o) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    // Pointers carry one extra bit so full and empty stay distinguishable.
    assign level_o   = wr_ptr_q - rd_ptr_q;
    assign empty_o   = (level_o == '0);
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/fx2_stream_feeder.sv
// rtl/fx2_stream_feeder.sv - FX2 slave-FIFO reader feeding the audio interface data_req/data_ok handshake
module fx2_stream_feeder
    import fx2_stream_feeder_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int START_LEVEL = 8,
    parameter int DATA_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     fx2_empty_n,
    input  logic [DATA_W-1:0]        fx2_fd,
    output logic                     fx2_sloe_n,
    output logic                     fx2_slrd_n,
    input  logic                     data_req,
    output logic                     data_ok,
    output logic [DATA_W-1:0]        data_out,
    output logic                     start_n,
    output logic                     stop_n,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underrun
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FILL_LIMIT = LW'(DEPTH - 3);
    localparam logic [LW-1:0] START_LVL  = LW'(START_LEVEL);

    localparam logic [SERVE_CNT_W-1:0] SERVE_IDLE_C  = '0;
    localparam logic [SERVE_CNT_W-1:0] SERVE_SETUP_C = SERVE_CNT_W'(SERVE_SETUP_CYCLES);
    localparam logic [SERVE_CNT_W-1:0] SERVE_LAST_C  = SERVE_CNT_W'(SERVE_LAST);

    feeder_state_e           state_q, state_d;
    logic                    sloe_n_q, slrd_n_q;
    logic                    req_meta_q, req_sync_q, req_prev_q;
    logic [SERVE_CNT_W-1:0]  serve_cnt_q, serve_cnt_d;
    logic                    pending_q, pending_d;
    logic                    data_ok_q, data_ok_d;
    logic [DATA_W-1:0]       data_out_q, data_out_d;
    logic                    start_n_q, start_n_d;
    logic                    stop_n_q, stop_n_d;
    logic                    underrun_q, underrun_d;

    logic                    req_rise;
    logic                    serve_idle;
    logic                    serve_start;
    logic                    fifo_wr;
    logic                    fifo_pop;
    logic                    fifo_empty;
    logic [DATA_W-1:0]       fifo_rd_data;
    logic [LW-1:0]           fifo_level;

    assign req_rise   = req_sync_q & ~req_prev_q;
    assign serve_idle = (serve_cnt_q == SERVE_IDLE_C);
    assign fifo_wr    = (fx2_slrd_n == FX2_STROBE_ON) && (fx2_empty_n != FX2_EMPTY_N_ACTIVE);

    fx2_stream_feeder_sample_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_sample_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (state_q == IDLE),
        .wr_en_i   (fifo_wr),
        .wr_data_i (fx2_fd),
        .rd_en_i   (fifo_pop),
        .rd_data_o (fifo_rd_data),
        .level_o   (fifo_level),
        .empty_o   (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        serve_cnt_d = serve_cnt_q;
        pending_d   = pending_q;
        data_out_d  = data_out_q;
        underrun_d  = underrun_q;
        start_n_d   = 1'b1;
        stop_n_d    = 1'b1;
        serve_start = 1'b0;
        fifo_pop    = 1'b0;

        if (!serve_idle) begin
            serve_cnt_d = (serve_cnt_q == SERVE_LAST_C) ? SERVE_IDLE_C : serve_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                pending_d  = 1'b0;
                underrun_d = 1'b0;
                if (enable) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                pending_d = 1'b0;
                if (!enable) begin
                    state_d = IDLE;
                end else if (fifo_level >= START_LVL) begin
                    start_n_d = 1'b0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // One request may queue behind a busy serve; further ones are dropped.
                if (serve_idle) begin
                    serve_start = pending_q | req_rise;
                    pending_d   = 1'b0;
                end else if (req_rise) begin
                    pending_d = 1'b1;
                end
                if (!enable) begin
                    stop_n_d = 1'b0;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                pending_d = 1'b0;
                if (serve_idle) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (serve_start) begin
            serve_cnt_d = SERVE_IDLE_C + 1'b1;
            fifo_pop    = !fifo_empty;
            data_out_d  = fifo_empty ? '0 : fifo_rd_data;
            if (fifo_empty) begin
                underrun_d = 1'b1;
            end
        end

        data_ok_d = (serve_cnt_d > SERVE_SETUP_C);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sloe_n_q    <= FX2_STROBE_OFF;
            slrd_n_q    <= FX2_STROBE_OFF;
            req_meta_q  <= 1'b0;
            req_sync_q  <= 1'b0;
            req_prev_q  <= 1'b0;
            serve_cnt_q <= SERVE_IDLE_C;
            pending_q   <= 1'b0;
            data_ok_q   <= 1'b0;
            data_out_q  <= '0;
            start_n_q   <= 1'b1;
            stop_n_q    <= 1'b1;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sloe_n_q    <= ~enable;
            // Read only while there is room for the word already in flight.
            slrd_n_q    <= ~(enable & fx2_empty_n & (fifo_level <= FILL_LIMIT) & (state_q != IDLE));
            req_meta_q  <= data_req;
            req_sync_q  <= req_meta_q;
            req_prev_q  <= req_sync_q;
            serve_cnt_q <= serve_cnt_d;
            pending_q   <= pending_d;
            data_ok_q   <= data_ok_d;
            data_out_q  <= data_out_d;
            start_n_q   <= start_n_d;
            stop_n_q    <= stop_n_d;
            underrun_q  <= underrun_d;
        end
    end

    assign fx2_sloe_n = sloe_n_q;
    assign fx2_slrd_n = slrd_n_q;
    assign data_ok    = data_ok_q;
    assign data_out   = data_out_q;
    assign start_n    = start_n_q;
    assign stop_n     = stop_n_q;
    assign level      = fifo_level;
    assign underrun   = underrun_q;

endmodule
